sr_readback_rx: RTL

//  Multi-channel receiver for serial readback of configuration shift registers.
//  - On a load_sr start pulse, waits a fixed pipeline skip, then captures WIDTH serial bits per channel.
//  - Commits the parallel word behind a valid/ready handshake, with overrun detection.
//  - Sits between the SR readback pins and the host/register interface.

---
 rtl/sr_pkg.sv | 26 ++
 rtl/sr_rx_lane.sv | 53 +++++
 rtl/sr_readback_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR readback transmit/receive sides:
// one-hot FSM state encodings and a constant-safe ceil(log2) helper.
package sr_pkg;

    localparam logic [4:0] SR_IDLE  = 5'b00001;
    localparam logic [4:0] SR_SKIP  = 5'b00010;
    localparam logic [4:0] SR_SHIFT = 5'b00100;
    localparam logic [4:0] SR_PAR   = 5'b01000;
    localparam logic [4:0] SR_DONE  = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE  = SR_IDLE,
        ST_SKIP  = SR_SKIP,
        ST_SHIFT = SR_SHIFT,
        ST_PAR   = SR_PAR,
        ST_DONE  = SR_DONE
    } sr_state_t;

    function automatic int sr_clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/sr_rx_lane.sv
// One readback lane: shadow register written one bit at a time at bit_idx.
// With SR_RX_PARITY_EN, also keeps running parity over data plus parity bit.
module sr_rx_lane #(
    parameter int WIDTH = 170,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [CW-1:0]    bit_idx,
    input  logic             din,
    output logic [WIDTH-1:0] shadow
`ifdef SR_RX_PARITY_EN
    ,
    input  logic             par_en,
    output logic             par_acc
`endif
);

    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] shadow_reg;

    // Decode the bit index into a one-hot write mask.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign wr_mask[gi] = sample_en && (bit_idx == CW'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= (shadow_reg & ~wr_mask) | (wr_mask & {WIDTH{din}});
        end
    end

    assign shadow = shadow_reg;

`ifdef SR_RX_PARITY_EN
    logic par_acc_reg;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            par_acc_reg <= 1'b0;
        end else if (sample_en || par_en) begin
            par_acc_reg <= par_acc_reg ^ din;
        end
    end

    assign par_acc = par_acc_reg;
`endif

endmodule

// File: rtl/sr_readback_rx.sv
// Multi-lane SR readback receiver: skip, capture WIDTH bits per lane, commit
// behind valid/ready with sticky overrun. Optional parity: SR_RX_PARITY_EN.
module sr_readback_rx
    import sr_pkg::*;
#(
    parameter int WIDTH       = 170,
    parameter int NCH         = 1,
    parameter int SKIP_CYCLES = 1,
    parameter int LSB_FIRST   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_sr,
    input  logic [NCH-1:0]       dout_sr,
    output logic                 busy,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overrun
`ifdef SR_RX_PARITY_EN
    ,
    output logic [NCH-1:0]       parity_err
`endif
);

    localparam int CW = sr_clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [3:0]    SKIP_LAST = (SKIP_CYCLES == 0) ? 4'd0 : 4'(SKIP_CYCLES - 1);

    sr_state_t state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic [3:0]           skip_reg;
    logic                 sample_en;
    logic                 clr;
    logic [CW-1:0]        bit_idx;
    logic [NCH*WIDTH-1:0] shadow_all;
`ifdef SR_RX_PARITY_EN
    logic                 par_en;
    logic [NCH-1:0]       par_all;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            skip_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_reg == ST_SHIFT) ? cnt_reg + 1'b1 : '0;
            skip_reg  <= (state_reg == ST_SKIP)  ? skip_reg + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_next = state_reg;
        sample_en  = 1'b0;
        clr        = 1'b0;
`ifdef SR_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (load_sr) begin
                    clr        = 1'b1;
                    state_next = (SKIP_CYCLES == 0) ? ST_SHIFT : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (skip_reg == SKIP_LAST) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                sample_en = 1'b1;
                if (cnt_reg == CNT_LAST) begin
`ifdef SR_RX_PARITY_EN
                    state_next = ST_PAR;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef SR_RX_PARITY_EN
            ST_PAR: begin
                par_en     = 1'b1;
                state_next = ST_DONE;
            end
`endif
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign bit_idx = (LSB_FIRST != 0) ? cnt_reg : CNT_LAST - cnt_reg;
    assign busy    = (state_reg != ST_IDLE);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
        sr_rx_lane #(
            .WIDTH (WIDTH),
            .CW    (CW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .sample_en (sample_en),
            .bit_idx   (bit_idx),
            .din       (dout_sr[gi]),
            .shadow    (shadow_all[gi*WIDTH +: WIDTH])
`ifdef SR_RX_PARITY_EN
            ,
            .par_en    (par_en),
            .par_acc   (par_all[gi])
`endif
        );
    end

    // A commit with a simultaneous ready consumes the old word, so no overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SR_RX_PARITY_EN
            parity_err <= '0;
`endif
        end else if (state_reg == ST_DONE) begin
            dout       <= shadow_all;
            dout_valid <= 1'b1;
            if (dout_valid && !dout_ready) overrun <= 1'b1;
`ifdef SR_RX_PARITY_EN
            parity_err <= par_all;
`endif
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
